// File: rtl/bnn_pkg.sv
// Shared definitions for the folded binary neural-network layer:
// FSM state encoding and elaboration-time width helpers.
package bnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Popcount/threshold width: must represent every count 0..n inclusive.
    function automatic int calc_cw(input int n);
        return clog2(n + 1);
    endfunction

    function automatic int idx_width(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational W-bit XNOR followed by a population count of the matches.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter  int W  = 16,
    localparam int PW = clog2(W + 1)
) (
    input  logic [W-1:0]  act_i,
    input  logic [W-1:0]  weight_i,
    output logic [PW-1:0] count_o
);

    logic [W-1:0] match;

    // NOTE: every signal written in always_comb gets a value before any branch or loop, so no latch is inferred.
    always_comb begin
        match   = ~(act_i ^ weight_i);
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + PW'(match[i]);
        end
    end

endmodule

// File: rtl/bnn_folded_layer.sv
// Folded BNN layer: one W-bit slice per cycle for P neurons at a time,
// S*G cycles per vector, result held until the consumer accepts it.
module bnn_folded_layer
    import bnn_pkg::*;
#(
    parameter  int N       = 64,
    parameter  int W       = 16,
    parameter  int NEURONS = 8,
    parameter  int P       = 4,
    localparam int CW      = calc_cw(N),
    localparam int AW      = idx_width(NEURONS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N-1:0]            in_vector,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [N-1:0]            wr_weight,
    input  logic [CW-1:0]           wr_thresh,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NEURONS-1:0]      out_vector,
    output logic [NEURONS*CW-1:0]   out_popcounts,
    output logic                    busy
);

    localparam int S  = N / W;
    localparam int G  = NEURONS / P;
    localparam int PW = clog2(W + 1);
    localparam int SW = idx_width(S);
    localparam int GW = idx_width(G);

    state_e state_q, state_d;

    logic [W-1:0]       weights_q [NEURONS][S];
    logic [CW-1:0]      thresh_q  [NEURONS];
    logic [W-1:0]       vec_q     [S];
    logic [SW-1:0]      slice_q;
    logic [GW-1:0]      group_q;
    logic [CW-1:0]      acc_q     [P];
    logic [NEURONS-1:0] out_vec_q;
    logic [CW-1:0]      out_pop_q [NEURONS];

    logic               last_slice;
    logic               last_group;
    logic               wr_ok;
    logic [W-1:0]       act_slice;
    logic [AW-1:0]      nidx      [P];
    logic [W-1:0]       w_slice   [P];
    logic [PW-1:0]      pop       [P];
    logic [CW-1:0]      sum       [P];

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign out_vector = out_vec_q;

    assign last_slice = (slice_q == SW'(S - 1));
    assign last_group = (group_q == GW'(G - 1));
    assign act_slice  = vec_q[slice_q];

    // Writes are honoured only while idle, so a running pass always sees a frozen weight set.
    assign wr_ok = wr_en && (state_q == ST_IDLE) && (32'(wr_addr) < NEURONS);

    always_comb begin
        for (int k = 0; k < P; k++) begin
            nidx[k]    = AW'(int'(group_q) * P + k);
            w_slice[k] = weights_q[nidx[k]][slice_q];
            sum[k]     = acc_q[k] + CW'(pop[k]);
        end
    end

    for (genvar k = 0; k < P; k++) begin : g_lane
        bnn_xnor_popcount #(
            .W (W)
        ) u_popcount (
            .act_i    (act_slice),
            .weight_i (w_slice[k]),
            .count_o  (pop[k])
        );
    end

    for (genvar i = 0; i < NEURONS; i++) begin : g_pop_out
        assign out_popcounts[(i+1)*CW-1 -: CW] = out_pop_q[i];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (in_valid)                  state_d = ST_ACCUM;
            ST_ACCUM: if (last_slice && last_group)  state_d = ST_DONE;
            ST_DONE:  if (out_ready)                 state_d = ST_IDLE;
            default:                                 state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the weight/threshold arrays are reset as well; after rst the layer computes from all-zero parameters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slice_q   <= '0;
            group_q   <= '0;
            out_vec_q <= '0;
            for (int n = 0; n < NEURONS; n++) begin
                thresh_q[n]  <= '0;
                out_pop_q[n] <= '0;
                for (int s = 0; s < S; s++) begin
                    weights_q[n][s] <= '0;
                end
            end
            for (int s = 0; s < S; s++) begin
                vec_q[s] <= '0;
            end
            for (int k = 0; k < P; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            if (wr_ok) begin
                thresh_q[wr_addr] <= wr_thresh;
                for (int s = 0; s < S; s++) begin
                    weights_q[wr_addr][s] <= wr_weight[s*W +: W];
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        slice_q <= '0;
                        group_q <= '0;
                        for (int s = 0; s < S; s++) begin
                            vec_q[s] <= in_vector[s*W +: W];
                        end
                        for (int k = 0; k < P; k++) begin
                            acc_q[k] <= '0;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (last_slice) begin
                        slice_q <= '0;
                        group_q <= last_group ? '0 : group_q + 1'b1;
                        for (int k = 0; k < P; k++) begin
                            out_pop_q[nidx[k]] <= sum[k];
                            out_vec_q[nidx[k]] <= (sum[k] >= thresh_q[nidx[k]]);
                            acc_q[k]           <= '0;
                        end
                    end else begin
                        slice_q <= slice_q + 1'b1;
                        for (int k = 0; k < P; k++) begin
                            acc_q[k] <= sum[k];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bnn_folded_layer.sv
// Scoreboard bench for bnn_folded_layer: a driver issues writes and vectors and
// queues model predictions; a monitor compares every accepted result.
module tb_bnn_folded_layer;

    localparam int N       = 64;
    localparam int W       = 16;
    localparam int NEURONS = 8;
    localparam int P       = 4;
    localparam int CW      = $clog2(N + 1);
    localparam int AW      = $clog2(NEURONS);
    localparam int LAT     = (N / W) * (NEURONS / P);

    typedef struct {
        logic [NEURONS-1:0]    bits;
        logic [NEURONS*CW-1:0] pops;
        int                    acc_cyc;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [N-1:0]          in_vector = '0;
    logic                  wr_en = 1'b0;
    logic [AW-1:0]         wr_addr = '0;
    logic [N-1:0]          wr_weight = '0;
    logic [CW-1:0]         wr_thresh = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [NEURONS-1:0]    out_vector;
    logic [NEURONS*CW-1:0] out_popcounts;
    logic                  busy;

    exp_t         exp_q[$];
    logic [N-1:0] mdl_w  [NEURONS];
    int           mdl_th [NEURONS];
    bit           mdl_busy = 1'b0;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic         prev_valid = 1'b0;

    bnn_folded_layer #(
        .N       (N),
        .W       (W),
        .NEURONS (NEURONS),
        .P       (P)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_vector     (in_vector),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_weight     (wr_weight),
        .wr_thresh     (wr_thresh),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_vector    (out_vector),
        .out_popcounts (out_popcounts),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic logic [N-1:0] rand_vec();
        return {$urandom, $urandom};
    endfunction

    // Reference: neuron n fires when the count of agreeing bits reaches its threshold.
    function automatic exp_t predict(input logic [N-1:0] v);
        exp_t e;
        int   pc;
        e.bits = '0;
        e.pops = '0;
        e.acc_cyc = 0;
        for (int n = 0; n < NEURONS; n++) begin
            pc = $countones(~(v ^ mdl_w[n]));
            e.pops[n*CW +: CW] = CW'(pc);
            e.bits[n] = (pc >= mdl_th[n]);
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NEURONS; n++) begin
            mdl_w[n]  = '0;
            mdl_th[n] = 0;
        end
    endtask

    task automatic wr(input int addr, input logic [N-1:0] w, input int th);
        wr_en     = 1'b1;
        wr_addr   = AW'(addr);
        wr_weight = w;
        wr_thresh = CW'(th);
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (!mdl_busy && addr < NEURONS) begin
            mdl_w[addr]  = w;
            mdl_th[addr] = th;
        end
    endtask

    task automatic send(input logic [N-1:0] v);
        exp_t e;
        int   t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("in_ready_before_send", in_ready, 1'b1);
        in_valid  = 1'b1;
        in_vector = v;
        e = predict(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.acc_cyc = cyc;
        exp_q.push_back(e);
        mdl_busy = 1'b1;
        check("busy_after_accept", busy, 1'b1);
    endtask

    // Waits for the result, optionally stalling the consumer for `hold` cycles.
    task automatic wait_done(input int hold);
        int t;
        t = 0;
        out_ready = (hold == 0);
        while (!out_valid && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("done_timeout", out_valid, 1'b1);
        for (int i = 0; i < hold; i++) begin
            in_valid  = 1'b1;
            in_vector = rand_vec();
            check("hold_out_valid", out_valid, 1'b1);
            check("hold_in_ready", in_ready, 1'b0);
            if (exp_q.size() > 0) begin
                check("hold_out_vector", out_vector, exp_q[0].bits);
                check("hold_out_popcounts", out_popcounts, exp_q[0].pops);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        mdl_busy = 1'b0;
        check("idle_in_ready", in_ready, 1'b1);
        check("idle_out_valid", out_valid, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) check("unexpected_out_valid", out_valid, 1'b0);
                else check("latency", cyc - exp_q[0].acc_cyc, LAT);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_vector", out_vector, e.bits);
                    check("out_popcounts", out_popcounts, e.pops);
                end
            end
        end
        prev_valid <= out_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] v;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_vector", out_vector, '0);
        check("rst_out_popcounts", out_popcounts, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // All-zero weights and input, thresholds at half scale.
        for (int n = 0; n < NEURONS; n++) wr(n, '0, 32);
        send('0);
        wait_done(0);

        // Neuron 3 weight is the inverse of the input: zero agreement.
        v = rand_vec();
        wr(3, ~v, 0);
        send(v);
        wait_done(0);
        wr(3, ~v, 1);
        send(v);
        wait_done(0);

        // Full agreement against thresholds just above and at N.
        v = rand_vec();
        wr(5, v, N + 1);
        send(v);
        wait_done(0);
        wr(5, v, N);
        send(v);
        wait_done(0);

        // Consumer stalls in DONE while a new vector is offered.
        send(rand_vec());
        wait_done(5);

        // A write during ACCUM must not disturb the running pass.
        v = rand_vec();
        send(v);
        wr(0, ~v, 0);
        check("accum_busy", busy, 1'b1);
        wait_done(0);
        wr(0, ~v, 0);
        send(v);
        wait_done(0);

        for (int it = 0; it < 14; it++) begin
            int nw;
            nw = $urandom_range(1, 3);
            for (int j = 0; j < nw; j++) begin
                int th;
                th = ($urandom_range(0, 7) == 0) ? 127 : $urandom_range(0, N + 6);
                wr($urandom_range(0, NEURONS - 1), rand_vec(), th);
            end
            send(rand_vec());
            wait_done($urandom_range(0, 3));
        end

        // Reset in the third ACCUM cycle.
        send(rand_vec());
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_out_vector", out_vector, '0);
        exp_q.delete();
        mdl_busy = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_midrst_in_ready", in_ready, 1'b1);
        send(rand_vec());
        wait_done(0);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bnn_folded_layer.md
BNN_FOLDED_LAYER -- requirements
Module: bnn_folded_layer

Interface
REQ-001 SHALL have parameter N, default 64: input vector bit-width.
REQ-002 SHALL have parameter W, default 16: input slice width processed per cycle; N SHALL be a multiple of W.
REQ-003 SHALL have parameter NEURONS, default 8: total neurons in the layer.
REQ-004 SHALL have parameter P, default 4: neurons evaluated in parallel per pass; NEURONS SHALL be a multiple of P.
REQ-005 SHALL derive the following: CW = clog2(N+1) (popcount/threshold width); S = N/W (slices); G = NEURONS/P (groups).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  1  in_vector offered.
REQ-009 in_ready  output  1  block can accept a vector.
REQ-010 in_vector  input  N  binary activation vector.
REQ-011 wr_en  input  1  weight/threshold write strobe.
REQ-012 wr_addr  input  clog2(NEURONS)  target neuron index.
REQ-013 wr_weight  input  N  weight row for that neuron.
REQ-014 wr_thresh  input  CW  threshold for that neuron.
REQ-015 out_valid  output  1  result held for consumer.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_vector  output  NEURONS  activation bit per neuron, bit i = neuron i.
REQ-018 out_popcounts  output  NEURONS*CW  popcount of neuron i in bits [(i+1)*CW-1 -: CW].
REQ-019 busy  output  1  high in ACCUM or DONE.

Function
REQ-020 SHALL store NEURONS weight rows (N bits) and thresholds (CW bits) in internal registers.
REQ-021 SHALL write row/threshold wr_addr on wr_en only in IDLE; wr_en in ACCUM/DONE and wr_addr >= NEURONS SHALL be ignored.
REQ-022 FSM states: IDLE, ACCUM, DONE; in_ready = (state == IDLE), combinational.
REQ-023 IDLE: on in_valid && in_ready SHALL latch in_vector, clear slice/group counters and accumulators, go to ACCUM.
REQ-024 ACCUM: each cycle SHALL add popcount(XNOR(slice s of input, slice s of weight)) into the accumulators of the P neurons of group g, slice s = bits [(s+1)*W-1 -: W].
REQ-025 Slice counter SHALL advance 0..S-1, then wrap to 0 and advance the group counter.
REQ-026 On the last slice of a group, SHALL register the popcount and bit = (popcount >= threshold), unsigned CW-bit compare, for each of its P neurons.
REQ-027 After the last slice of group G-1, SHALL enter DONE with out_valid = 1; latency = S*G clock edges from acceptance (8 at defaults).
REQ-028 DONE: out_valid, out_vector and out_popcounts SHALL hold stable until out_valid && out_ready, then go to IDLE with out_valid = 0.
REQ-029 Threshold 0 SHALL always yield bit 1; a threshold greater than N SHALL always yield bit 0.
REQ-030 Weight writes SHALL NOT alter an in-flight computation; new values apply from the next accepted vector.

Reset
REQ-031 rst SHALL force IDLE, counters 0, accumulators 0, out_valid 0, out_vector 0, out_popcounts 0, busy 0, all weights 0, all thresholds 0, effective immediately, including mid-ACCUM or mid-DONE.
REQ-032 After rst deasserts, in_ready SHALL be 1.

Structure
REQ-033 Shared package bnn_pkg SHALL hold the FSM state enum, the clog2 function and the CW derivation.
REQ-034 SHALL instantiate P copies of sub-module bnn_xnor_popcount (combinational W-bit XNOR + popcount, clog2(W+1)-bit result).

Verification (N=64, W=16, NEURONS=8, P=4)
REQ-035 All weights 0, in_vector 0, thresholds 32 -> out_vector 0xFF, every popcount 64, out_valid 8 edges after accept.
REQ-036 Neuron 3 weight = ~in_vector -> popcount3 = 0; threshold3 = 0 -> bit3 = 1; threshold3 = 1 -> bit3 = 0.
REQ-037 Threshold 65, popcount 64 -> bit 0; threshold 64 -> bit 1.
REQ-038 out_ready held low 5 cycles in DONE -> outputs stable, in_ready 0, in_valid not accepted; out_ready high -> IDLE next edge.
REQ-039 wr_en to neuron 0 during ACCUM -> current result unchanged; same write in IDLE -> takes effect on next vector.
REQ-040 rst at 3rd ACCUM cycle -> out_valid 0, in_ready 1, weights 0; next vector with thresholds 0 -> out_vector 0xFF.
